branch_dispatch_queue: RTL and testbench



---
 rtl/branch_dispatch_queue_pkg.sv | 10 +
 rtl/branch_dispatch_queue_fifo.sv | 46 ++++
 rtl/branch_dispatch_queue.sv | 103 ++++++++++
 tb/tb_branch_dispatch_queue.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_dispatch_queue_pkg.sv
// branch_dispatch_queue_pkg: shared constants for the branch dispatch queue.
package branch_dispatch_queue_pkg;

    // Branch count produced by instruction decode.
    localparam int N_INSTR_BRANCHES = 4;

    // Drop counter saturation value.
    localparam int DROP_MAX = 255;

endpackage

// File: rtl/branch_dispatch_queue_fifo.sv
// dispatch_fifo: single-clock FIFO with occupancy count and synchronous flush.
module dispatch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Pointers wrap naturally; full/empty come from count alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage array needs no reset; only occupied slots are ever read out.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/branch_dispatch_queue.sv
// branch_dispatch_queue: FIFO plus output register steering instructions to one-hot branches.
module branch_dispatch_queue
    import branch_dispatch_queue_pkg::*;
#(
    parameter int PAYLOAD_W  = 128,
    parameter int N_BRANCHES = N_INSTR_BRANCHES,
    parameter int DEPTH      = 4,
    localparam int BW        = $clog2(N_BRANCHES),
    localparam int LW        = $clog2(DEPTH + 2)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BW-1:0]         in_branch,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    output logic [N_BRANCHES-1:0] out_valid,
    input  logic [N_BRANCHES-1:0] out_ready,
    output logic [PAYLOAD_W-1:0]  out_payload,
    output logic [LW-1:0]         level,
    output logic [7:0]            drop_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int W  = BW + PAYLOAD_W;

    logic [CW-1:0]        fifo_count;
    logic [W-1:0]         fifo_rdata;
    logic                 hold_valid;
    logic [BW-1:0]        hold_branch;
    logic [PAYLOAD_W-1:0] hold_payload;
    logic                 accept;
    logic                 in_range;
    logic                 store;
    logic                 deliver;
    logic                 hold_load;
    logic                 fifo_empty;
    logic                 pop;
    logic                 bypass;
    logic                 push;

    // in_ready only looks at registered state, never at out_ready.
    assign in_ready   = reset_n & enable & ~flush & (fifo_count < CW'(DEPTH));
    assign accept     = in_valid & in_ready;
    assign in_range   = int'(in_branch) < N_BRANCHES;
    assign store      = accept & in_range;
    assign out_valid  = enable ? (N_BRANCHES'(hold_valid) << hold_branch) : '0;
    assign deliver    = |(out_valid & out_ready);
    assign hold_load  = enable & (~hold_valid | deliver);
    assign fifo_empty = fifo_count == '0;
    assign pop        = hold_load & ~fifo_empty;
    assign bypass     = hold_load & fifo_empty & store;
    assign push       = store & ~bypass;

    assign out_payload = hold_payload;
    assign level       = LW'(fifo_count) + LW'(hold_valid);

    dispatch_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .push    (push),
        .wdata   ({in_branch, in_payload}),
        .pop     (pop),
        .rdata   (fifo_rdata),
        .count   (fifo_count)
    );

    // Output register: refill from FIFO head first, else bypass the input, else go empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid   <= 1'b0;
            hold_branch  <= '0;
            hold_payload <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (hold_load) begin
            hold_valid <= pop | bypass;
            if (pop) begin
                hold_branch  <= fifo_rdata[PAYLOAD_W +: BW];
                hold_payload <= fifo_rdata[PAYLOAD_W-1:0];
            end else if (bypass) begin
                hold_branch  <= in_branch;
                hold_payload <= in_payload;
            end
        end
    end

    // Out-of-range branches are consumed and counted, saturating.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (accept && !in_range && drop_count != 8'(DROP_MAX)) begin
            drop_count <= drop_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_branch_dispatch_queue.sv
// tb_branch_dispatch_queue: directed and randomized checks against a queue-based model.
module tb_branch_dispatch_queue;

    localparam int PW    = 128;
    localparam int NB    = 3;
    localparam int DEPTH = 4;
    localparam int BW    = 2;
    localparam int LW    = 3;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] in_branch = '0;
    logic [PW-1:0] in_payload = '0;
    logic [NB-1:0] out_valid;
    logic [NB-1:0] out_ready = '0;
    logic [PW-1:0] out_payload;
    logic [LW-1:0] level;
    logic [7:0]    drop_count;

    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int            br;
        logic [PW-1:0] pl;
    } item_t;

    item_t mq[$];
    int    mdrop = 0;
    logic  m_acc;

    branch_dispatch_queue #(
        .PAYLOAD_W  (PW),
        .N_BRANCHES (NB),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_branch   (in_branch),
        .in_payload  (in_payload),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (out_payload),
        .level       (level),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Everything in flight lives in mq; the head (if any) is the one on the output.
    function automatic int fcnt();
        return (mq.size() > 0) ? mq.size() - 1 : 0;
    endfunction

    function automatic logic exp_ready();
        return enable && !flush && fcnt() < DEPTH;
    endfunction

    function automatic logic [NB-1:0] exp_valid();
        logic [NB-1:0] v;
        v = '0;
        if (enable && mq.size() > 0) v[mq[0].br] = 1'b1;
        return v;
    endfunction

    // Reference model advances on each rising edge from the inputs present before it.
    initial forever begin
        @(posedge clk);
        if (reset_n) begin
            if (flush) begin
                mq.delete();
            end else if (enable) begin
                m_acc = in_valid && exp_ready();
                if (mq.size() > 0 && out_ready[mq[0].br]) void'(mq.pop_front());
                if (m_acc) begin
                    if (in_branch < NB) mq.push_back('{int'(in_branch), in_payload});
                    else if (mdrop < 255) mdrop++;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("in_ready", PW'(in_ready), PW'(exp_ready()));
            chk("out_valid", PW'(out_valid), PW'(exp_valid()));
            chk("level", PW'(level), PW'(mq.size()));
            chk("drop_count", PW'(drop_count), PW'(mdrop));
            if (mq.size() > 0) chk("out_payload", out_payload, mq[0].pl);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [PW-1:0] rand_pl();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", PW'(out_valid), '0);
        chk("rst_out_payload", out_payload, '0);
        chk("rst_in_ready", PW'(in_ready), '0);
        reset_n = 1'b1;
        tick();
        chk("rst_level", PW'(level), '0);
        chk("rst_drop", PW'(drop_count), '0);

        // Single instruction through the bypass path.
        enable = 1'b1;
        out_ready = '1;
        in_valid = 1'b1;
        in_branch = 2'd2;
        in_payload = PW'(8'hA5);
        tick();
        in_valid = 1'b0;
        chk("bypass_valid", PW'(out_valid), PW'(3'b100));
        chk("bypass_payload", out_payload, PW'(8'hA5));
        tick();
        chk("bypass_level", PW'(level), '0);

        // Fill with ready low: only DEPTH+1 accepted, then drain in order.
        out_ready = '0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_branch = 2'd0;
            in_payload = PW'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        chk("full_level", PW'(level), PW'(5));
        chk("full_in_ready", PW'(in_ready), '0);
        out_ready = 3'b001;
        for (int k = 1; k <= 5; k++) begin
            chk("drain_payload", out_payload, PW'(k));
            tick();
            if (k == 1) chk("drain_in_ready", PW'(in_ready), PW'(1));
        end
        chk("drain_level", PW'(level), '0);

        // Head-of-line blocking on a stalled branch.
        out_ready = '0;
        in_valid = 1'b1;
        in_branch = 2'd1;
        in_payload = PW'(8'h11);
        tick();
        in_branch = 2'd0;
        in_payload = PW'(8'h22);
        tick();
        in_valid = 1'b0;
        out_ready = 3'b001;
        tick();
        tick();
        chk("hol_level", PW'(level), PW'(2));
        chk("hol_valid", PW'(out_valid), PW'(3'b010));
        chk("hol_payload", out_payload, PW'(8'h11));
        out_ready = 3'b011;
        tick();
        chk("hol_next_valid", PW'(out_valid), PW'(3'b001));
        chk("hol_next_payload", out_payload, PW'(8'h22));
        tick();
        chk("hol_level_end", PW'(level), '0);

        // Flush with three entries buffered.
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_branch = 2'd0;
            in_payload = PW'(8'h40 + i);
            tick();
        end
        in_valid = 1'b0;
        chk("pre_flush_level", PW'(level), PW'(3));
        flush = 1'b1;
        #1;
        chk("flush_in_ready", PW'(in_ready), '0);
        tick();
        flush = 1'b0;
        chk("flush_level", PW'(level), '0);
        chk("flush_valid", PW'(out_valid), '0);
        chk("flush_drop", PW'(drop_count), '0);

        // Enable low masks and freezes; re-enable delivers the same head.
        in_valid = 1'b1;
        in_branch = 2'd1;
        in_payload = PW'(8'h33);
        tick();
        in_valid = 1'b0;
        enable = 1'b0;
        out_ready = '1;
        #1;
        chk("dis_valid", PW'(out_valid), '0);
        repeat (3) tick();
        chk("dis_level", PW'(level), PW'(1));
        enable = 1'b1;
        #1;
        chk("reen_valid", PW'(out_valid), PW'(3'b010));
        chk("reen_payload", out_payload, PW'(8'h33));
        tick();
        chk("reen_level", PW'(level), '0);

        // Out-of-range branch: consumed, counted, saturating.
        in_valid = 1'b1;
        in_branch = 2'd3;
        for (int i = 0; i < 300; i++) tick();
        in_valid = 1'b0;
        chk("drop_sat", PW'(drop_count), PW'(255));
        chk("drop_level", PW'(level), '0);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                in_valid = 1'b1;
                out_ready = '0;
                enable = 1'b1;
                flush = 1'b0;
                tick();
                reset_n = 1'b0;
                #1;
                chk("async_rst_valid", PW'(out_valid), '0);
                chk("async_rst_level", PW'(level), '0);
                chk("async_rst_in_ready", PW'(in_ready), '0);
                chk("async_rst_drop", PW'(drop_count), '0);
                mq.delete();
                mdrop = 0;
                tick();
                reset_n = 1'b1;
            end
            enable = $urandom_range(0, 9) != 0;
            flush = $urandom_range(0, 39) == 0;
            in_valid = $urandom_range(0, 1) == 1;
            in_branch = ($urandom_range(0, 15) == 0) ? 2'd3 : BW'($urandom_range(0, 2));
            in_payload = rand_pl();
            out_ready = ((i / 200) % 2 == 1) ? NB'($urandom()) : NB'($urandom() & $urandom() & $urandom());
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
